// File: rtl/dsp_seq_pkg.sv
// Shared types and constants for the time-multiplexed multiply-add datapath.
// Provides the ALU opcodes, the sequencer states and the default data width.
package dsp_seq_pkg;

  localparam int default_width = 8;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_MUL = 1'b1
  } alu_op_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL  = 3'd1,
    ADD1 = 3'd2,
    ADD2 = 3'd3,
    ADD3 = 3'd4,
    DONE = 3'd5
  } state_t;

endpackage

// File: rtl/dsp_alu.sv
// Combinational width-bit ALU shared by every step of the program.
// Results are modular 2^width, so signed and unsigned operands give the same bits.
module dsp_alu
  import dsp_seq_pkg::*;
#(
  parameter int width = default_width
) (
  input  alu_op_t          op,
  input  logic [width-1:0] x,
  input  logic [width-1:0] z,
  output logic [width-1:0] r
);

  // Select the multiplier or adder result; truncation happens through the result width.
  always_comb begin
    r = '0;
    case (op)
      OP_MUL:  r = x * z;
      OP_ADD:  r = x + z;
      default: r = '0;
    endcase
  end

endmodule

// File: rtl/dsp_seq_mul_add3.sv
// Serial evaluation of y = (b*c + a) + (b*c + d) on one shared ALU,
// with valid/ready handshakes on both the operand and the result side.
module dsp_seq_mul_add3
  import dsp_seq_pkg::*;
#(
  parameter int width = default_width
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  input  logic [width-1:0] c,
  input  logic [width-1:0] d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] y
);

  state_t           state_r;
  logic [width-1:0] a_r, b_r, c_r, d_r;
  logic [width-1:0] t0_r, t1_r, t2_r, y_r;
  logic             in_ready_r, out_valid_r;

  alu_op_t          alu_op_s;
  logic [width-1:0] alu_x_s, alu_z_s, alu_r_s;

  // Operand muxes: the state alone chooses which registers feed the ALU.
  always_comb begin
    alu_op_s = OP_ADD;
    alu_x_s  = '0;
    alu_z_s  = '0;
    case (state_r)
      MUL: begin
        alu_op_s = OP_MUL;
        alu_x_s  = b_r;
        alu_z_s  = c_r;
      end
      ADD1: begin
        alu_x_s = t0_r;
        alu_z_s = a_r;
      end
      ADD2: begin
        alu_x_s = t0_r;
        alu_z_s = d_r;
      end
      ADD3: begin
        alu_x_s = t1_r;
        alu_z_s = t2_r;
      end
      default: begin
        alu_op_s = OP_ADD;
        alu_x_s  = '0;
        alu_z_s  = '0;
      end
    endcase
  end

  dsp_alu #(.width(width)) u_alu (
    .op (alu_op_s),
    .x  (alu_x_s),
    .z  (alu_z_s),
    .r  (alu_r_s)
  );

  // Sequencer, operand capture, intermediates and registered handshake outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= IDLE;
      a_r         <= '0;
      b_r         <= '0;
      c_r         <= '0;
      d_r         <= '0;
      t0_r        <= '0;
      t1_r        <= '0;
      t2_r        <= '0;
      y_r         <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r        <= a;
            b_r        <= b;
            c_r        <= c;
            d_r        <= d;
            in_ready_r <= 1'b0;
            state_r    <= MUL;
          end
        end
        MUL: begin
          t0_r    <= alu_r_s;
          state_r <= ADD1;
        end
        ADD1: begin
          t1_r    <= alu_r_s;
          state_r <= ADD2;
        end
        ADD2: begin
          t2_r    <= alu_r_s;
          state_r <= ADD3;
        end
        ADD3: begin
          y_r         <= alu_r_s;
          out_valid_r <= 1'b1;
          state_r     <= DONE;
        end
        DONE: begin
          // Result is consumed here; the next operand set waits for IDLE.
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign y         = y_r;

endmodule

// File: doc/dsp_seq_mul_add3.md
# dsp_seq_mul_add3

Time-multiplexed, handshaked implementation of the fan-out dataflow y = (b*c + a) + (b*c + d) on a single shared DSP ALU. It executes the four-op program serially and reuses the stored mul result for both adds. It complements the spatial four-DSP version: one DSP slice instead of four, at reduced throughput. It sits between an upstream operand producer and a downstream result consumer, both using valid/ready.

## Interface

Parameters:
- width, 8, data width of operands, intermediates and result (all i-width).

Ports:
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  operand set a/b/c/d valid.
- in_ready  out  1  block can accept an operand set.
- a  in  width  addend to mul result (t1 path).
- b  in  width  multiplicand.
- c  in  width  multiplier.
- d  in  width  addend to mul result (t2 path).
- out_valid  out  1  y holds a completed result.
- out_ready  in  1  consumer accepts y.
- y  out  width  result t3.

## Operation

- FSM states: IDLE, MUL, ADD1, ADD2, ADD3, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, capture a,b,c,d into operand registers and go to MUL.
- MUL: ALU op=mul(b,c); t0 register loads result; go to ADD1.
- ADD1: ALU op=add(t0,a); t1 register loads; go to ADD2.
- ADD2: ALU op=add(t0,d); t2 register loads; go to ADD3.
- ADD3: ALU op=add(t1,t2); y register loads; go to DONE.
- DONE: out_valid=1. On out_ready, go to IDLE. Otherwise hold, with y and out_valid stable.
- in_ready = (state==IDLE) only. No accept in DONE, even if out_ready=1 the same cycle.
- Arithmetic is modular 2^width. Products and sums are truncated to the low width bits. Signed and unsigned interpretation give identical bits, so no sign handling is needed.
- Operands are captured once. Changes on a..d after the accept have no effect on the in-flight computation.
- Reset, in any state including mid-computation: state→IDLE, in_ready=1, out_valid=0, y=0, t0/t1/t2/operand registers=0. Any in-flight result is discarded.
- in_valid during reset is ignored. The first accept is possible in the first cycle after reset deasserts.

## Timing

- Accept at edge N (handshake in cycle N-1→state MUL in cycle N). t0 is valid from N+1, t1 from N+2, t2 from N+3, y from N+4. out_valid=1 from cycle N+4 (DONE).
- Latency, accept edge to out_valid: 4 cycles. Minimum initiation interval: 6 cycles (IDLE, 4 compute, DONE with out_ready=1).
- Backpressure: out_valid is held indefinitely while out_ready=0; in_ready stays 0 meanwhile.
- All outputs are registered or decoded from state only. There is no combinational path from in_valid/out_ready to any output.

## Structure

- Shared package dsp_seq_pkg holds:
  - the opcode enum {OP_ADD, OP_MUL};
  - the state enum {IDLE, MUL, ADD1, ADD2, ADD3, DONE};
  - the default width constant.
- Sub-module dsp_alu: a combinational width-bit ALU (op, x, z → r). It is instantiated once, with operand muxes selected by state. Its mul must map to the DSP multiplier.
- Top level holds the FSM, operand/intermediate registers and handshake.

## Test plan

- Basic: a=1,b=2,c=3,d=4, out_ready=1 → out_valid rises 4 cycles after accept, y=17 (0x11), one-cycle pulse, in_ready back to 1 next cycle.
- Wrap: a=200,b=16,c=16,d=100 → t0=0, y=44 (0x2C).
- Signed bits: a=0x01,b=0xFF,c=0x02,d=0x03 → t0=0xFE, t1=0xFF, t2=0x01, y=0x00.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → y and out_valid stable, in_ready=0, new in_valid not accepted; on release, result is consumed and the next operand set is accepted in IDLE.
- Operand isolation: change a..d every cycle after accept → y matches the captured set only.
- Reset mid-op: assert reset in ADD2 → next cycle out_valid=0, y=0, in_ready=1; a fresh accept yields the correct result with no residue from the aborted run.
